// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract over a WIDTH-bit operand pair,
// DIGIT bits per clock, least-significant digit first. Start/busy/done
// handshake, optional signed saturation, and carry/overflow/zero/negative flags.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M,
    input  logic             SAT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;

    // Operand A register doubles as the result accumulator: each consumed
    // digit of A is shifted out at the bottom while its sum digit enters at
    // the top, so after K steps the register holds the raw sum.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             sat_q;
    logic             a_sign;

    logic [DIGIT:0]   dsum;
    logic             cin_msb;
    logic             cout_msb;
    logic             ovf;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] final_s;

    wire accept = start && (state != RUN);

    // Clamp to the signed range on overflow; the sign of A alone tells which
    // way the overflow went, for both add and subtract.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             overflow,
        input logic             enable,
        input logic             sign
    );
        if (enable && overflow)
            return sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return raw;
    endfunction

    // Digit ripple add, carry into/out of the MSB, and the next accumulator value.
    always_comb begin
        dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};
        // sum bit = a ^ b ^ cin, so the carry into the top bit falls out directly
        cin_msb  = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        cout_msb = dsum[DIGIT];
        ovf      = cin_msb ^ cout_msb;
        nxt_a    = a_sh >> DIGIT;
        nxt_a[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
        final_s  = saturate(nxt_a, ovf, sat_q, a_sign);
    end

    // Datapath: latch operands on accept, then shift one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= A;
            b_sh   <= B ^ {WIDTH{M}};
            sat_q  <= SAT;
            a_sign <= A[WIDTH-1];
            carry  <= M;
        end else if (state == RUN) begin
            a_sh   <= nxt_a;
            b_sh   <= b_sh >> DIGIT;
            carry  <= dsum[DIGIT];
        end
    end

    // Sequencer and registered result/flags; outputs update on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            S     <= '0;
            Co    <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
            N     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt == LAST) begin
                        S     <= final_s;
                        Co    <= cout_msb;
                        V     <= ovf;
                        Z     <= (final_s == '0);
                        N     <= final_s[WIDTH-1];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: a 4-bit-digit instance and a single-digit one.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        M = 1'b0;
    logic        SAT = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;

    logic [15:0] S, S2;
    logic        Co, V, Z, N, busy, done;
    logic        Co2, V2, Z2, N2, busy2, done2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .M(M), .SAT(SAT),
        .A(A), .B(B), .S(S), .Co(Co), .V(V), .Z(Z), .N(N),
        .busy(busy), .done(done)
    );

    addsub_seq #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .M(M), .SAT(SAT),
        .A(A), .B(B), .S(S2), .Co(Co2), .V(V2), .Z(Z2), .N(N2),
        .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation on the DIGIT=4 instance and wait (bounded) for done.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic sat,
                         input logic [15:0] exp_s, input logic [3:0] exp_flags);
        int n;
        A = a; B = b; M = m; SAT = sat; start = 1'b1;
        tick();
        start = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_S"}, S, exp_s);
        check({tag, "_CoVZN"}, {Co, V, Z, N}, exp_flags);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {S, Co, V, Z, N, busy, done}, '0);
        check("reset_outputs_d16", {S2, Co2, V2, Z2, N2, busy2, done2}, '0);
        rst_n = 1'b1;
        tick();

        do_op("add",       16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 4'b0000);
        do_op("sub_zero",  16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b1010);
        do_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101);
        do_op("pos_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0100);
        do_op("neg_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 4'b1100);
        do_op("neg_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101);

        // start held high through RUN with changing operands
        A = 16'h0001; B = 16'h0002; M = 1'b0; SAT = 1'b0; start = 1'b1;
        tick();
        check("hold_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            A = 16'hAAAA + 16'(i); B = 16'h5555;
            tick();
            check("hold_no_done", {busy, done}, 2'b10);
        end
        A = 16'h0100; B = 16'h0010;
        tick();
        check("hold_done", done, 1'b1);
        check("hold_S", S, 16'h0003);
        // start still high in the done cycle: accepted at the next edge
        tick();
        start = 1'b0;
        check("b2b_busy", {busy, done}, 2'b10);
        check("b2b_S_held", S, 16'h0003);
        tick(); tick(); tick();
        check("b2b_not_yet", done, 1'b0);
        tick();
        check("b2b_done", done, 1'b1);
        check("b2b_S", S, 16'h0110);
        tick();

        // Reset mid-RUN
        A = 16'h1234; B = 16'h0001; M = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset", {S, Co, V, Z, N, busy, done}, '0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010);

        // Single-digit instance: two-edge latency
        A = 16'h1234; B = 16'h0FFF; M = 1'b0; SAT = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("d16_busy", {busy2, done2}, 2'b10);
        tick();
        check("d16_done", {busy2, done2}, 2'b01);
        check("d16_S", S2, 16'h2233);
        check("d16_CoVZN", {Co2, V2, Z2, N2}, 4'b0000);
        tick();
        check("d16_idle", done2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
